led_axil_slave: RTL

- AXI4-Lite slave (responder) that fronts the LED block: four 32-bit read/write registers plus a prescaled blink/PWM engine that drives the LED pins.
- Sits behind the AXI4-Lite master in the block design and is the target of the register write/read-back test sequence.
- All register bits are stored in full, so any written word reads back unchanged; the LED engine uses only a subset of the bits.

---
 rtl/led_axil_pkg.sv | 17 +
 rtl/led_pwm_engine.sv | 66 ++++++
 rtl/led_axil_slave.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/led_axil_pkg.sv
// Shared constants for the LED AXI4-Lite block: register offsets, LED mode codes, response codes.
package led_axil_pkg;

   // Register select, i.e. byte address bits [3:2]
   localparam logic [1:0] ADDR_MODE     = 2'd0;
   localparam logic [1:0] ADDR_PRESCALE = 2'd1;
   localparam logic [1:0] ADDR_DUTY     = 2'd2;
   localparam logic [1:0] ADDR_INVERT   = 2'd3;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PWM   = 2'b11;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/led_pwm_engine.sv
// LED drive engine: prescaler tick, 8-bit phase counter and per-LED off/on/blink/pwm
// selection with a registered, polarity-adjusted output.
module led_pwm_engine
   import led_axil_pkg::*;
#(
   parameter int N_LEDS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       mode,
   input  logic [31:0]       prescale,
   input  logic [31:0]       duty,
   input  logic [31:0]       invert,
   input  logic              prescale_clr,
   output logic [N_LEDS-1:0] led
);

   logic [31:0]       presc_cnt;
   logic [7:0]        phase;
   logic              tick;
   logic [N_LEDS-1:0] raw;
   logic              unused_bits;

   // Only the low DUTY byte, 2*N_LEDS MODE bits and N_LEDS INVERT bits steer the LEDs
   assign unused_bits = ^{mode, duty[31:8], invert};

   assign tick = (presc_cnt == prescale);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         phase     <= '0;
      end else begin
         if (prescale_clr || tick) begin
            presc_cnt <= '0;
         end else begin
            presc_cnt <= presc_cnt + 32'd1;
         end
         if (tick) begin
            phase <= phase + 8'd1;
         end
      end
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         case (mode[2*i +: 2])
            MODE_OFF:   raw[i] = 1'b0;
            MODE_ON:    raw[i] = 1'b1;
            MODE_BLINK: raw[i] = phase[7];
            MODE_PWM:   raw[i] = (phase < duty[7:0]);
            default:    raw[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= raw ^ invert[N_LEDS-1:0];
      end
   end

endmodule

// File: rtl/led_axil_slave.sv
// AXI4-Lite responder holding the four LED control registers; drives the LED pins through
// led_pwm_engine.
module led_axil_slave
   import led_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int N_LEDS             = 8
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [N_LEDS-1:0]               led_o
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   logic                          aw_ready;
   logic                          w_ready;
   logic                          b_valid;
   logic                          ar_ready;
   logic                          r_valid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
   logic [C_S_AXI_DATA_WIDTH-1:0] reg_mode;
   logic [C_S_AXI_DATA_WIDTH-1:0] reg_prescale;
   logic [C_S_AXI_DATA_WIDTH-1:0] reg_duty;
   logic [C_S_AXI_DATA_WIDTH-1:0] reg_invert;
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
   logic                          wr_fire;
   logic                          rd_fire;
   logic [1:0]                    wr_sel;
   logic [1:0]                    rd_sel;
   logic                          prescale_clr;
   logic                          unused_in;

   assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_strb(
      input logic [C_S_AXI_DATA_WIDTH-1:0] cur,
      input logic [C_S_AXI_DATA_WIDTH-1:0] data,
      input logic [STRB_W-1:0]             strb
   );
      logic [C_S_AXI_DATA_WIDTH-1:0] res;
      res = cur;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   // The address and data phases complete together on the edge that closes the READY pulse
   assign wr_fire      = aw_ready && S_AXI_AWVALID && w_ready && S_AXI_WVALID;
   assign rd_fire      = ar_ready && S_AXI_ARVALID;
   assign wr_sel       = S_AXI_AWADDR[3:2];
   assign rd_sel       = S_AXI_ARADDR[3:2];
   assign prescale_clr = wr_fire && (wr_sel == ADDR_PRESCALE);

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
      end else begin
         if (S_AXI_AWVALID && S_AXI_WVALID && !b_valid && !aw_ready) begin
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
         end else begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
         end
         if (wr_fire) begin
            b_valid <= 1'b1;
         end else if (S_AXI_BREADY) begin
            b_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         reg_mode     <= '0;
         reg_prescale <= '0;
         reg_duty     <= '0;
         reg_invert   <= '0;
      end else if (wr_fire) begin
         case (wr_sel)
            ADDR_MODE:     reg_mode     <= merge_strb(reg_mode, S_AXI_WDATA, S_AXI_WSTRB);
            ADDR_PRESCALE: reg_prescale <= merge_strb(reg_prescale, S_AXI_WDATA, S_AXI_WSTRB);
            ADDR_DUTY:     reg_duty     <= merge_strb(reg_duty, S_AXI_WDATA, S_AXI_WSTRB);
            ADDR_INVERT:   reg_invert   <= merge_strb(reg_invert, S_AXI_WDATA, S_AXI_WSTRB);
            default:       ;
         endcase
      end
   end

   always_comb begin
      rd_word = reg_mode;
      case (rd_sel)
         ADDR_MODE:     rd_word = reg_mode;
         ADDR_PRESCALE: rd_word = reg_prescale;
         ADDR_DUTY:     rd_word = reg_duty;
         ADDR_INVERT:   rd_word = reg_invert;
         default:       rd_word = reg_mode;
      endcase
   end

   // A same-edge write is not yet visible here, so a colliding read returns the old word
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= '0;
      end else begin
         ar_ready <= S_AXI_ARVALID && !r_valid && !ar_ready;
         if (rd_fire) begin
            r_data  <= rd_word;
            r_valid <= 1'b1;
         end else if (S_AXI_RREADY) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_BVALID  = b_valid;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RVALID  = r_valid;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = RESP_OKAY;

   led_pwm_engine #(
      .N_LEDS(N_LEDS)
   ) u_engine (
      .clk          (S_AXI_ACLK),
      .rst_n        (S_AXI_ARESETN),
      .mode         (reg_mode),
      .prescale     (reg_prescale),
      .duty         (reg_duty),
      .invert       (reg_invert),
      .prescale_clr (prescale_clr),
      .led          (led_o)
   );

endmodule
